// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the mult/div sequencer and the decoder that feeds it.
// State encoding, exception codes and the ALU field values for mult/div.
package multdiv_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } md_state_e;

   localparam logic [2:0] ExcNone = 3'd0;
   localparam logic [2:0] ExcMult = 3'd4;
   localparam logic [2:0] ExcDiv  = 3'd5;

   localparam logic [4:0] AluMult = 5'b00110;
   localparam logic [4:0] AluDiv  = 5'b00111;

   // Decoder helper: true for either mult/div ALU field value.
   function automatic logic is_multdiv(input logic [4:0] alu_op);
      return (alu_op == AluMult) || (alu_op == AluDiv);
   endfunction

   // Decoder helper: req_op value for a mult/div ALU field (0 = mult, 1 = div).
   function automatic logic alu_to_op(input logic [4:0] alu_op);
      return alu_op == AluDiv;
   endfunction

   function automatic logic [2:0] exc_code(input logic op);
      return op ? ExcDiv : ExcMult;
   endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Per-operation cycle counter for the WAIT state; flags the watchdog limit.
// Clear has priority over enable; terminal is high on the last allowed cycle.
module md_cycle_counter #(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned TIMEOUT = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign terminal = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mult/div request through the iterative unit: start pulse, stall
// while iterating, one-cycle response, with flush abort and a watchdog timeout.
module multdiv_sequencer
   import multdiv_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT = 40,
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned OPS_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             flush,
   output logic             md_ctrl_mult,
   output logic             md_ctrl_div,
   output logic [31:0]      md_a,
   output logic [31:0]      md_b,
   input  logic [31:0]      md_result,
   input  logic             md_exception,
   input  logic             md_ready,
   output logic             stall,
   output logic             rsp_valid,
   output logic [31:0]      rsp_result,
   output logic             rsp_exception,
   output logic [2:0]       rsp_exc_code,
   output logic             busy,
   output logic [OPS_W-1:0] ops_done
);

   md_state_e        state_q;
   logic             op_q;
   logic             md_ctrl_mult_q;
   logic             md_ctrl_div_q;
   logic [31:0]      md_a_q;
   logic [31:0]      md_b_q;
   logic             rsp_valid_q;
   logic [31:0]      rsp_result_q;
   logic             rsp_exception_q;
   logic [2:0]       rsp_exc_code_q;
   logic [OPS_W-1:0] ops_q;
   logic             cnt_clear;
   logic             cnt_enable;
   logic             cnt_terminal;

   assign cnt_clear  = (state_q == StIssue);
   assign cnt_enable = (state_q == StWait);

   md_cycle_counter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_cycle_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (cnt_enable),
      .terminal (cnt_terminal)
   );

   // Pulse and response registers default low so each lasts exactly one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= StIdle;
         op_q            <= 1'b0;
         md_ctrl_mult_q  <= 1'b0;
         md_ctrl_div_q   <= 1'b0;
         md_a_q          <= '0;
         md_b_q          <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_result_q    <= '0;
         rsp_exception_q <= 1'b0;
         rsp_exc_code_q  <= ExcNone;
         ops_q           <= '0;
      end else begin
         md_ctrl_mult_q  <= 1'b0;
         md_ctrl_div_q   <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_result_q    <= '0;
         rsp_exception_q <= 1'b0;
         rsp_exc_code_q  <= ExcNone;
         unique case (state_q)
            StIdle: begin
               if (req_valid && !flush) begin
                  op_q           <= req_op;
                  md_a_q         <= req_a;
                  md_b_q         <= req_b;
                  md_ctrl_mult_q <= ~req_op;
                  md_ctrl_div_q  <= req_op;
                  state_q        <= StIssue;
               end
            end
            StIssue: begin
               // md_ready may still be high from the previous op; not looked at here.
               state_q <= flush ? StIdle : StWait;
            end
            StWait: begin
               if (flush) begin
                  state_q <= StIdle;
               end else if (md_ready) begin
                  rsp_valid_q     <= 1'b1;
                  rsp_result_q    <= md_result;
                  rsp_exception_q <= md_exception;
                  rsp_exc_code_q  <= md_exception ? exc_code(op_q) : ExcNone;
                  state_q         <= StDone;
               end else if (cnt_terminal) begin
                  rsp_valid_q     <= 1'b1;
                  rsp_result_q    <= '0;
                  rsp_exception_q <= 1'b1;
                  rsp_exc_code_q  <= exc_code(op_q);
                  state_q         <= StDone;
               end
            end
            StDone: begin
               ops_q   <= ops_q + OPS_W'(1);
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign md_ctrl_mult  = md_ctrl_mult_q;
   assign md_ctrl_div   = md_ctrl_div_q;
   assign md_a          = md_a_q;
   assign md_b          = md_b_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_exception = rsp_exception_q;
   assign rsp_exc_code  = rsp_exc_code_q;
   assign ops_done      = ops_q;
   assign busy          = (state_q != StIdle);

   // The accept term must freeze the pipeline in the same cycle the request is seen.
   assign stall = (state_q == StIdle && req_valid && !flush && !reset)
                  || (state_q == StIssue) || (state_q == StWait);

`ifndef SYNTHESIS
   a_ctrl_exclusive: assert property (@(posedge clock) disable iff (reset)
      !(md_ctrl_mult && md_ctrl_div));
   a_ctrl_single: assert property (@(posedge clock) disable iff (reset)
      (md_ctrl_mult || md_ctrl_div) |=> !(md_ctrl_mult || md_ctrl_div));
`endif

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: vector table plus hand sequences for flush,
// back-to-back and mid-op reset; responses checked through a scoreboard queue.
module tb_multdiv_sequencer;

   localparam int unsigned TIMEOUT = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        md_ctrl_mult;
   logic        md_ctrl_div;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_ready;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_result;
   logic        rsp_exception;
   logic [2:0]  rsp_exc_code;
   logic        busy;
   logic [15:0] ops_done;

   multdiv_sequencer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (6),
      .OPS_W   (16)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .flush         (flush),
      .md_ctrl_mult  (md_ctrl_mult),
      .md_ctrl_div   (md_ctrl_div),
      .md_a          (md_a),
      .md_b          (md_b),
      .md_result     (md_result),
      .md_exception  (md_exception),
      .md_ready      (md_ready),
      .stall         (stall),
      .rsp_valid     (rsp_valid),
      .rsp_result    (rsp_result),
      .rsp_exception (rsp_exception),
      .rsp_exc_code  (rsp_exc_code),
      .busy          (busy),
      .ops_done      (ops_done)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_mult_pulse = 0;
   int n_div_pulse = 0;
   logic prev_pulse = 1'b0;
   logic [15:0] exp_ops = '0;

   typedef struct {
      logic [31:0] result;
      logic        exc;
      logic [2:0]  code;
   } exp_rsp_t;
   exp_rsp_t sb_q[$];

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      int          ready_at;   // WAIT cycle (1-based) with md_ready high; 0 = never
      logic        stale;      // md_ready/md_exception high during ISSUE
      logic [31:0] unit_result;
      logic        unit_exc;
      logic [31:0] exp_result;
      logic        exp_exc;
      logic [2:0]  exp_code;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset) begin
         check("ctrl_exclusive", 64'(md_ctrl_mult & md_ctrl_div), 0);
         check("ctrl_single_cycle", 64'(prev_pulse & (md_ctrl_mult | md_ctrl_div)), 0);
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               exp_rsp_t e;
               e = sb_q.pop_front();
               check("sb_result", rsp_result, e.result);
               check("sb_exception", rsp_exception, e.exc);
               check("sb_exc_code", rsp_exc_code, e.code);
            end
         end else begin
            check("rsp_zero_when_invalid", {rsp_result, rsp_exception, rsp_exc_code}, 0);
         end
      end
      prev_pulse   <= md_ctrl_mult | md_ctrl_div;
      n_mult_pulse <= n_mult_pulse + int'(md_ctrl_mult);
      n_div_pulse  <= n_div_pulse + int'(md_ctrl_div);
   end

   task automatic clear_unit();
      md_ready     = 1'b0;
      md_exception = 1'b0;
      md_result    = '0;
   endtask

   task automatic push_exp(input logic [31:0] r, input logic x, input logic [2:0] c);
      exp_rsp_t e;
      e.result = r;
      e.exc    = x;
      e.code   = c;
      sb_q.push_back(e);
   endtask

   // Runs one op from IDLE to the IDLE cycle after DONE.
   task automatic run_vec(input vec_t v, input int idx);
      int waits;
      int m0;
      int d0;
      waits = (v.ready_at > 0) ? v.ready_at : int'(TIMEOUT);
      m0 = n_mult_pulse;
      d0 = n_div_pulse;
      req_valid = 1'b1;
      req_op    = v.op;
      req_a     = v.a;
      req_b     = v.b;
      flush     = 1'b0;
      push_exp(v.exp_result, v.exp_exc, v.exp_code);
      #1;
      check($sformatf("v%0d_accept_stall", idx), stall, 1);
      tick();
      req_valid    = 1'b0;
      req_a        = $urandom;
      req_b        = $urandom;
      md_ready     = v.stale;
      md_exception = v.stale;
      md_result    = 32'hdead_beef;
      #1;
      check($sformatf("v%0d_pulse_mult", idx), md_ctrl_mult, !v.op);
      check($sformatf("v%0d_pulse_div", idx), md_ctrl_div, v.op);
      check($sformatf("v%0d_md_a", idx), md_a, v.a);
      check($sformatf("v%0d_md_b", idx), md_b, v.b);
      check($sformatf("v%0d_issue_stall", idx), stall, 1);
      for (int k = 1; k <= waits; k++) begin
         tick();
         clear_unit();
         if (k == v.ready_at) begin
            md_ready     = 1'b1;
            md_result    = v.unit_result;
            md_exception = v.unit_exc;
         end
         #1;
         check($sformatf("v%0d_wait%0d_stall", idx, k), stall, 1);
         check($sformatf("v%0d_wait%0d_rsp", idx, k), rsp_valid, 0);
      end
      tick();
      clear_unit();
      #1;
      check($sformatf("v%0d_done_rsp_valid", idx), rsp_valid, 1);
      check($sformatf("v%0d_done_stall", idx), stall, 0);
      check($sformatf("v%0d_done_md_a_held", idx), md_a, v.a);
      tick();
      exp_ops = exp_ops + 16'd1;
      #1;
      check($sformatf("v%0d_ops_done", idx), ops_done, exp_ops);
      check($sformatf("v%0d_idle_busy", idx), busy, 0);
      check($sformatf("v%0d_idle_rsp", idx), rsp_valid, 0);
      check($sformatf("v%0d_mult_pulses", idx), n_mult_pulse - m0, v.op ? 0 : 1);
      check($sformatf("v%0d_div_pulses", idx), n_div_pulse - d0, v.op ? 1 : 0);
   endtask

   initial begin
      int c_first;
      vecs[0] = '{1'b0, 32'd7,   32'd6,   17, 1'b0, 32'd42, 1'b0, 32'd42, 1'b0, 3'd0};
      vecs[1] = '{1'b1, 32'd5,   32'd0,   4,  1'b0, 32'd0,  1'b1, 32'd0,  1'b1, 3'd5};
      vecs[2] = '{1'b0, 32'hffff_ffff, 32'd2, 0, 1'b0, 32'd9, 1'b0, 32'd0, 1'b1, 3'd4};
      vecs[3] = '{1'b1, 32'd100, 32'd7,   1,  1'b1, 32'd14, 1'b0, 32'd14, 1'b0, 3'd0};
      vecs[4] = '{1'b0, 32'd3,   32'd5,   2,  1'b1, 32'd15, 1'b1, 32'd15, 1'b1, 3'd4};
      vecs[5] = '{1'b1, 32'd770, 32'd10,  40, 1'b0, 32'd77, 1'b0, 32'd77, 1'b0, 3'd0};

      reset = 1'b1;
      req_valid = 1'b0;
      req_op = 1'b0;
      req_a = '0;
      req_b = '0;
      flush = 1'b0;
      clear_unit();
      tick();
      req_valid = 1'b1;
      #1;
      check("reset_stall_forced_low", stall, 0);
      tick();
      reset = 1'b0;
      req_valid = 1'b0;
      #1;
      check("reset_outputs", {md_ctrl_mult, md_ctrl_div, rsp_valid, rsp_exception, rsp_exc_code},
            0);
      check("reset_md_ab", {md_a, md_b}, 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_busy", busy, 0);
      check("reset_stall", stall, 0);
      check("reset_ops_done", ops_done, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Flush while IDLE blocks the accept.
      req_valid = 1'b1;
      req_op = 1'b0;
      flush = 1'b1;
      #1;
      check("idle_flush_stall", stall, 0);
      tick();
      req_valid = 1'b0;
      flush = 1'b0;
      #1;
      check("idle_flush_busy", busy, 0);

      // Flush in the third WAIT cycle.
      req_valid = 1'b1;
      req_op = 1'b0;
      req_a = 32'd3;
      req_b = 32'd9;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      flush = 1'b1;
      #1;
      check("wait_flush_stall", stall, 1);
      tick();
      flush = 1'b0;
      #1;
      check("wait_flush_busy", busy, 0);
      check("wait_flush_stall_after", stall, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         check("wait_flush_no_rsp", rsp_valid, 0);
      end
      check("wait_flush_ops", ops_done, exp_ops);

      // Flush in ISSUE aborts; flush in DONE is ignored.
      req_valid = 1'b1;
      req_op = 1'b1;
      tick();
      req_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("issue_flush_busy", busy, 0);
      req_valid = 1'b1;
      req_op = 1'b1;
      push_exp(32'd8, 1'b0, 3'd0);
      tick();
      req_valid = 1'b0;
      tick();
      md_ready = 1'b1;
      md_result = 32'd8;
      tick();
      clear_unit();
      flush = 1'b1;
      #1;
      check("done_flush_rsp_valid", rsp_valid, 1);
      tick();
      flush = 1'b0;
      exp_ops = exp_ops + 16'd1;
      #1;
      check("done_flush_ops", ops_done, exp_ops);

      // Back-to-back divides with req_valid held through DONE.
      req_valid = 1'b1;
      req_op = 1'b1;
      req_a = 32'd20;
      req_b = 32'd4;
      push_exp(32'd5, 1'b0, 3'd0);
      tick();
      c_first = cyc;
      #1;
      check("b2b_first_pulse", md_ctrl_div, 1);
      tick();
      md_ready = 1'b1;
      md_result = 32'd5;
      tick();
      clear_unit();
      req_a = 32'd9;
      req_b = 32'd3;
      push_exp(32'd3, 1'b0, 3'd0);
      #1;
      check("b2b_done_stall", stall, 0);
      check("b2b_done_rsp", rsp_valid, 1);
      tick();
      #1;
      check("b2b_accept_stall", stall, 1);
      check("b2b_accept_busy", busy, 0);
      tick();
      req_valid = 1'b0;
      #1;
      check("b2b_second_pulse", md_ctrl_div, 1);
      check("b2b_second_md_a", md_a, 32'd9);
      check("b2b_pulse_gap", cyc - c_first, 4);
      tick();
      md_ready = 1'b1;
      md_result = 32'd3;
      tick();
      clear_unit();
      tick();
      exp_ops = exp_ops + 16'd2;
      #1;
      check("b2b_ops_done", ops_done, exp_ops);

      // Reset in the middle of WAIT.
      req_valid = 1'b1;
      req_op = 1'b0;
      req_a = 32'd11;
      req_b = 32'd12;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_ops = '0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_md_a", md_a, 0);
      check("midreset_stall", stall, 0);
      check("midreset_ops", ops_done, exp_ops);
      for (int k = 0; k < 4; k++) tick();

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
